// File: rtl/matmul_sequencer.sv
// Tile matmul control unit for tinynpu_top: clears the accumulators, streams K
// vector pairs through the skewers, flushes the pipeline and waits for the drain.
package matmul_sequencer_pkg;
  typedef enum logic [1:0] {
    PREC_INT8 = 2'd0,
    PREC_INT4 = 2'd1,
    PREC_FP16 = 2'd2,
    PREC_BF16 = 2'd3
  } precision_mode_t;
endpackage

module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int ARRAY_SIZE    = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int KLEN_WIDTH    = 8,
  parameter int UB_RD_LAT     = 1,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] input_base,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [KLEN_WIDTH-1:0] k_len,
  input  precision_mode_t       precision_in,
  input  logic                  result_valid,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  skewer_en,
  output logic                  compute_enable,
  output logic                  drain_enable,
  output logic                  acc_clear,
  output precision_mode_t       precision_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int FLUSH_LEN = UB_RD_LAT + 2 * (ARRAY_SIZE - 1);
  localparam int PW        = KLEN_WIDTH + $clog2(FLUSH_LEN + 1) + 1;
  localparam int DW        = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] input_base_q;
  logic [ADDR_WIDTH-1:0] weight_base_q;
  logic [KLEN_WIDTH-1:0] k_len_q;
  logic [PW-1:0]         phase;
  logic [DW-1:0]         drain_cnt;
  logic [PW-1:0]         phase_nxt;
  logic [PW-1:0]         feed_last;
  logic [PW-1:0]         flush_last;

  // phase counts every FEED and FLUSH cycle; it doubles as the FEED vector index
  assign phase_nxt  = phase + PW'(1);
  assign feed_last  = PW'(k_len_q) - PW'(1);
  assign flush_last = PW'(k_len_q) + PW'(FLUSH_LEN - 1);

  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [PW-1:0]         off);
    return base + ADDR_WIDTH'(off);
  endfunction

  function automatic logic mac_window(input logic [PW-1:0] p);
    return p >= PW'(UB_RD_LAT);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      phase          <= '0;
      drain_cnt      <= '0;
      input_addr     <= '0;
      weight_addr    <= '0;
      skewer_en      <= 1'b0;
      compute_enable <= 1'b0;
      drain_enable   <= 1'b0;
      acc_clear      <= 1'b0;
      precision_mode <= PREC_INT8;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      // Cancel: drop every enable, keep addresses and mode for post-mortem
      state          <= S_IDLE;
      skewer_en      <= 1'b0;
      compute_enable <= 1'b0;
      drain_enable   <= 1'b0;
      acc_clear      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            error <= 1'b0;
            if (k_len != '0) begin
              input_base_q   <= input_base;
              weight_base_q  <= weight_base;
              k_len_q        <= k_len;
              precision_mode <= precision_in;
              acc_clear      <= 1'b1;
              state          <= S_CLEAR;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          acc_clear      <= 1'b0;
          skewer_en      <= 1'b1;
          phase          <= '0;
          compute_enable <= mac_window('0);
          input_addr     <= input_base_q;
          weight_addr    <= weight_base_q;
          state          <= S_FEED;
        end
        S_FEED: begin
          phase          <= phase_nxt;
          compute_enable <= mac_window(phase_nxt);
          if (phase == feed_last) begin
            state <= S_FLUSH;
          end else begin
            input_addr  <= wrap_addr(input_base_q, phase_nxt);
            weight_addr <= wrap_addr(weight_base_q, phase_nxt);
          end
        end
        S_FLUSH: begin
          if (phase == flush_last) begin
            skewer_en      <= 1'b0;
            compute_enable <= 1'b0;
            drain_enable   <= 1'b1;
            drain_cnt      <= '0;
            state          <= S_DRAIN;
          end else begin
            phase          <= phase_nxt;
            compute_enable <= mac_window(phase_nxt);
          end
        end
        S_DRAIN: begin
          if (result_valid || drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
            drain_enable <= 1'b0;
            done         <= 1'b1;
            error        <= !result_valid;
            state        <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: cycle-exact checks of one tile op,
// drain timeout, address wrap, k_len==0, abort, start-while-busy and reset.
module tb_matmul_sequencer;
  import matmul_sequencer_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [7:0]      input_base;
  logic [7:0]      weight_base;
  logic [7:0]      k_len;
  precision_mode_t precision_in;
  logic            result_valid;
  logic [7:0]      input_addr;
  logic [7:0]      weight_addr;
  logic            skewer_en;
  logic            compute_enable;
  logic            drain_enable;
  logic            acc_clear;
  precision_mode_t precision_mode;
  logic            busy;
  logic            done;
  logic            error;

  int passed = 0;
  int total  = 0;

  matmul_sequencer #(
    .ARRAY_SIZE(4), .ADDR_WIDTH(8), .KLEN_WIDTH(8), .UB_RD_LAT(1), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .input_base(input_base), .weight_base(weight_base), .k_len(k_len),
    .precision_in(precision_in), .result_valid(result_valid),
    .input_addr(input_addr), .weight_addr(weight_addr), .skewer_en(skewer_en),
    .compute_enable(compute_enable), .drain_enable(drain_enable), .acc_clear(acc_clear),
    .precision_mode(precision_mode), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // control bits in order {skewer_en, compute_enable, drain_enable, acc_clear, busy, done}
  function automatic logic [31:0] ctl();
    return {26'd0, skewer_en, compute_enable, drain_enable, acc_clear, busy, done};
  endfunction

  initial begin
    logic [7:0] wrap_exp [4];
    int n;
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;

    rst = 1'b1; start = 1'b0; abort = 1'b0; result_valid = 1'b0;
    input_base = 8'h00; weight_base = 8'h00; k_len = 8'd0; precision_in = PREC_INT8;
    tick(); tick();
    chk("reset ctl", ctl(), 32'h0);
    chk("reset addr", {16'd0, input_addr, weight_addr}, 32'h0);
    chk("reset err/prec", {29'd0, error, precision_mode}, 32'h0);
    rst = 1'b0;
    tick();

    // Basic op: k_len=4, bases 0x10/0x40, result_valid arrives at first DRAIN cycle
    input_base = 8'h10; weight_base = 8'h40; k_len = 8'd4; precision_in = PREC_FP16;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t1 clear", ctl(), 32'b000110);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) precision_in = PREC_INT4;
      chk($sformatf("feed%0d ctl", c), ctl(), (c == 0) ? 32'b100010 : 32'b110010);
      chk($sformatf("feed%0d addr", c), {16'd0, input_addr, weight_addr},
          {16'd0, 8'h10 + 8'(c), 8'h40 + 8'(c)});
    end
    for (int f = 0; f < 7; f++) begin
      tick();
      chk($sformatf("flush%0d ctl", f), ctl(), 32'b110010);
      chk($sformatf("flush%0d addr", f), {16'd0, input_addr, weight_addr}, 32'h1343);
    end
    tick();
    chk("t13 drain", ctl(), 32'b001010);
    chk("prec latched", 32'(precision_mode), 32'(PREC_FP16));
    result_valid = 1'b1;
    tick(); result_valid = 1'b0;
    chk("done ok ctl", ctl(), 32'b000011);
    chk("done ok err", 32'(error), 32'h0);
    tick();
    chk("idle after op", ctl(), 32'h0);

    // Drain timeout
    start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("to drain entry", ctl(), 32'b001010);
    n = 0;
    while (drain_enable && n < 40) begin
      n++;
      tick();
    end
    chk("to drain cycles", 32'(n), 32'd16);
    chk("to done ctl", ctl(), 32'b000011);
    chk("to done err", 32'(error), 32'h1);
    tick();
    chk("to idle ctl", ctl(), 32'h0);
    chk("to err held", 32'(error), 32'h1);

    // Address wrap, then abort in FLUSH
    input_base = 8'hFE;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("wrap err cleared", 32'(error), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("wrap addr%0d", c), 32'(input_addr), 32'(wrap_exp[c]));
    end
    tick();
    chk("wrap flush", ctl(), 32'b110010);
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("abort flush ctl", ctl(), 32'h0);
    chk("abort addr hold", 32'(input_addr), 32'h01);

    // k_len == 0
    k_len = 8'd0;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("k0 done ctl", ctl(), 32'b000011);
    chk("k0 err", 32'(error), 32'h0);
    tick();
    chk("k0 idle", ctl(), 32'h0);

    // Start while busy is ignored; abort in second FEED cycle
    input_base = 8'h10; k_len = 8'd4;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    start = 1'b1; input_base = 8'h80; k_len = 8'd9;
    tick(); start = 1'b0;
    chk("busy start ign", 32'(input_addr), 32'h11);
    abort = 1'b1; start = 1'b1;
    tick(); abort = 1'b0; start = 1'b0;
    chk("abort feed ctl", ctl(), 32'h0);
    tick();
    chk("abort no done", ctl(), 32'h0);

    // abort + start together in IDLE: start wins
    input_base = 8'h20; k_len = 8'd4;
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk("idle abort+start", ctl(), 32'b000110);
    tick();
    chk("fresh addr", {16'd0, input_addr, weight_addr}, 32'h2040);
    for (int i = 0; i < 11; i++) tick();
    chk("fresh drain", ctl(), 32'b001010);
    result_valid = 1'b1;
    tick(); result_valid = 1'b0;
    chk("fresh done", ctl(), 32'b000011);
    tick();

    // rst during FLUSH
    start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre-rst flush", ctl(), 32'b110010);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst ctl", ctl(), 32'h0);
    chk("rst addr", {16'd0, input_addr, weight_addr}, 32'h0);
    chk("rst err/prec", {29'd0, error, precision_mode}, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
